// File: rtl/vote_tally.sv
// Ballot-counting core: edge-detects debounced buttons, gates voting with a switch code,
// enforces a post-vote lockout and latches winner/tie on close. Optional lockout: VOTE_TALLY_LOCKOUT_EN.
module vote_tally #(
    parameter logic [15:0] OPEN_CODE      = 16'hA5C3,
    parameter int          CNT_W          = 8,
    parameter int          LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    input  logic                btn1,
    input  logic                btn2,
    input  logic                btn3,
    input  logic                btn4,
    input  logic                btn_ov_cv,
    input  logic [15:0]         sw,
    output logic [CNT_W-1:0]    cnt1,
    output logic [CNT_W-1:0]    cnt2,
    output logic [CNT_W-1:0]    cnt3,
    output logic [CNT_W-1:0]    cnt4,
    output logic [CNT_W+1:0]    total,
    output logic [1:0]          the_state,
    output logic [1:0]          the_winner,
    output logic                tie,
    output logic                vote_accept,
    output logic                vote_reject,
    output logic                enable_leds
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W+1:0] TOT_ONE = {{(CNT_W+1){1'b0}}, 1'b1};

`ifdef VOTE_TALLY_LOCKOUT_EN
    localparam int            LK_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_ONE  = {{(LK_W-1){1'b0}}, 1'b1};
    logic [LK_W-1:0] lk_q, lk_d;
`endif

    state_t                  state_q, state_d;
    logic [3:0]              btn_q, btn_d;
    logic                    ov_q, ov_d;
    logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W+1:0]        total_q, total_d;
    logic [1:0]              win_q, win_d;
    logic                    tie_q, tie_d;
    logic                    acc_q, acc_d;
    logic                    rej_q, rej_d;

    logic [3:0]              rise;
    logic                    ov_rise;
    logic                    rise_single;
    logic                    rise_multi;
    logic [1:0]              rise_idx;
    logic [1:0]              win_c;
    logic                    tie_c;
    logic [CNT_W-1:0]        max_c;
    logic [2:0]              n_max;

    assign btn_d       = {btn4, btn3, btn2, btn1};
    assign ov_d        = btn_ov_cv;
    assign rise        = btn_d & ~btn_q;
    assign ov_rise     = btn_ov_cv & ~ov_q & (sw == OPEN_CODE);
    assign rise_single = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
    assign rise_multi  = (rise != 4'd0) && !rise_single;

    always_comb begin
        rise_idx = 2'd0;
        case (rise)
            4'b0010: rise_idx = 2'd1;
            4'b0100: rise_idx = 2'd2;
            4'b1000: rise_idx = 2'd3;
            default: rise_idx = 2'd0;
        endcase
    end

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        max_c = cnt_q[0];
        win_c = 2'd0;
        n_max = 3'd0;
        for (int i = 1; i < 4; i++) begin
            if (cnt_q[i] > max_c) begin
                max_c = cnt_q[i];
                win_c = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (cnt_q[i] == max_c) n_max = n_max + 3'd1;
        end
        tie_c = (n_max > 3'd1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        win_d   = win_q;
        tie_d   = tie_q;
        acc_d   = 1'b0;
        rej_d   = 1'b0;
`ifdef VOTE_TALLY_LOCKOUT_EN
        lk_d    = lk_q;
`endif
        case (state_q)
            ST_CLOSED: begin
                if (ov_rise) state_d = ST_OPEN;
            end
            ST_OPEN: begin
                if (ov_rise) begin
                    state_d = ST_RESULT;
                    win_d   = win_c;
                    tie_d   = tie_c;
                end else if (rise_multi) begin
                    rej_d = 1'b1;
                end else if (rise_single) begin
                    if (cnt_q[rise_idx] == CNT_MAX) begin
                        rej_d = 1'b1;
                    end else begin
                        cnt_d[rise_idx] = cnt_q[rise_idx] + CNT_ONE;
                        total_d         = total_q + TOT_ONE;
                        acc_d           = 1'b1;
`ifdef VOTE_TALLY_LOCKOUT_EN
                        state_d         = ST_LOCKOUT;
                        lk_d            = LK_LOAD;
`endif
                    end
                end
            end
            ST_LOCKOUT: begin
`ifdef VOTE_TALLY_LOCKOUT_EN
                if (lk_q == '0) state_d = ST_OPEN;
                else            lk_d    = lk_q - LK_ONE;
`else
                state_d = ST_OPEN;
`endif
            end
            ST_RESULT: begin
                if (ov_rise) begin
                    state_d = ST_CLOSED;
                    cnt_d   = '0;
                    total_d = '0;
                end
            end
            default: state_d = ST_CLOSED;
        endcase
    end

    // Button registers reset high so a button held through reset never votes.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLOSED;
            btn_q   <= 4'hF;
            ov_q    <= 1'b1;
            cnt_q   <= '0;
            total_q <= '0;
            win_q   <= 2'd0;
            tie_q   <= 1'b0;
            acc_q   <= 1'b0;
            rej_q   <= 1'b0;
`ifdef VOTE_TALLY_LOCKOUT_EN
            lk_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            ov_q    <= ov_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            win_q   <= win_d;
            tie_q   <= tie_d;
            acc_q   <= acc_d;
            rej_q   <= rej_d;
`ifdef VOTE_TALLY_LOCKOUT_EN
            lk_q    <= lk_d;
`endif
        end
    end

    assign cnt1        = cnt_q[0];
    assign cnt2        = cnt_q[1];
    assign cnt3        = cnt_q[2];
    assign cnt4        = cnt_q[3];
    assign total       = total_q;
    assign the_state   = state_q;
    assign the_winner  = win_q;
    assign tie         = tie_q;
    assign vote_accept = acc_q;
    assign vote_reject = rej_q;
    assign enable_leds = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

endmodule
